pair_packer_ctrl: RTL and testbench

PAIR_PACKER_CTRL -- requirements
Module: pair_packer_ctrl

---
 rtl/pair_packer_ctrl.sv | 118 +++++++++++
 tb/tb_pair_packer_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_packer_ctrl.sv
// Pair packer: joins two 32-bit input words into one registered 64-bit output word.
// Define PAIR_PACKER_COUNT_EN to add the pair_count output and its counter.
module pair_packer_ctrl #(
  parameter logic [63:0] UUID = 64'd0,
  parameter string       NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_partial
`ifdef PAIR_PACKER_COUNT_EN
  ,
  output logic [31:0] pair_count
`endif
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StHalf  = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] low_q, low_d;
  logic [63:0] data_q, data_d;
  logic        partial_q, partial_d;
  logic        in_xfer, out_xfer;

  // Identification parameters are carried for the instance only.
  logic unused_params;
  assign unused_params = ^UUID ^ (NAME == "");

  assign out_valid   = (state_q == StFull);
  assign in_ready    = (state_q != StFull) | out_ready;
  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;
  assign out_data    = data_q;
  assign out_partial = partial_q;

  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    data_d    = data_q;
    partial_d = partial_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          low_d   = in_data;
          state_d = StHalf;
        end
      end
      StHalf: begin
        // An arriving high word always wins over a simultaneous flush.
        if (in_xfer) begin
          data_d    = {in_data, low_q};
          partial_d = 1'b0;
          state_d   = StFull;
        end else if (flush) begin
          data_d    = {32'h0, low_q};
          partial_d = 1'b1;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (out_xfer) begin
          if (in_xfer) begin
            low_d   = in_data;
            state_d = StHalf;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StEmpty;
      low_q     <= 32'h0;
      data_q    <= 64'h0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      data_q    <= data_d;
      partial_q <= partial_d;
    end
  end

`ifdef PAIR_PACKER_COUNT_EN
  logic [31:0] pair_count_q, pair_count_d;

  // Counts every output transfer, partial or full; wraps naturally.
  always_comb begin
    pair_count_d = pair_count_q;
    if (out_xfer) begin
      pair_count_d = pair_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pair_count_q <= 32'h0;
    end else begin
      pair_count_q <= pair_count_d;
    end
  end

  assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_pair_packer_ctrl.sv
// Bench for pair_packer_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pair_packer_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_partial;
`ifdef PAIR_PACKER_COUNT_EN
  logic [31:0] pair_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pair_packer_ctrl #(
    .UUID(64'h0123_4567_89AB_CDEF),
    .NAME("tb_inst")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_partial(out_partial)
`ifdef PAIR_PACKER_COUNT_EN
    ,
    .pair_count (pair_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending input words in a queue, one output slot.
  logic [31:0] pend[$];
  bit          m_full;
  logic [63:0] m_data;
  bit          m_part;
  logic [31:0] m_cnt;

  task automatic model_step();
    bit ix, ox;
    ox = m_full && out_ready;
    ix = in_valid && (!m_full || out_ready);
    if (!rst) begin
      pend.delete();
      m_full = 0;
      m_data = 64'h0;
      m_part = 0;
      m_cnt  = 32'h0;
    end else begin
      if (ox) begin
        m_full = 0;
        m_cnt  = m_cnt + 32'd1;
      end
      if (ix) pend.push_back(in_data);
      if (pend.size() == 2) begin
        m_data = {pend[1], pend[0]};
        m_part = 0;
        m_full = 1;
        pend.delete();
      end else if (flush && !ix && pend.size() == 1 && !m_full) begin
        m_data = {32'h0, pend[0]};
        m_part = 1;
        m_full = 1;
        pend.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model out_valid", {63'h0, out_valid}, {63'h0, m_full});
      chk("model in_ready", {63'h0, in_ready}, {63'h0, (!m_full || out_ready)});
      if (m_full) begin
        chk("model out_data", out_data, m_data);
        chk("model out_partial", {63'h0, out_partial}, {63'h0, m_part});
      end
`ifdef PAIR_PACKER_COUNT_EN
      chk("model pair_count", {32'h0, pair_count}, {32'h0, m_cnt});
`endif
    end
  end

  // One clock: returns just after the following negative edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit f, input bit ordy);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = ordy;
    #1;
  endtask

  logic [63:0] held;

  initial begin
    rst = 1'b0;
    drive(0, 32'h0, 0, 1);
    cyc();
    cyc();
    chk_en = 1;
    chk("reset out_valid", {63'h0, out_valid}, 64'h0);
    chk("reset out_data", out_data, 64'h0);
    chk("reset out_partial", {63'h0, out_partial}, 64'h0);
    chk("reset in_ready", {63'h0, in_ready}, 64'h1);
`ifdef PAIR_PACKER_COUNT_EN
    chk("reset pair_count", {32'h0, pair_count}, 64'h0);
`endif
    rst = 1'b1;

    // Basic pair
    drive(1, 32'h1111_1111, 0, 1);
    cyc();
    chk("basic half out_valid", {63'h0, out_valid}, 64'h0);
    drive(1, 32'h2222_2222, 0, 1);
    cyc();
    chk("basic out_valid", {63'h0, out_valid}, 64'h1);
    chk("basic out_data", out_data, 64'h2222_2222_1111_1111);
    chk("basic out_partial", {63'h0, out_partial}, 64'h0);
    drive(0, 32'h0, 0, 1);
    cyc();
    chk("basic drained", {63'h0, out_valid}, 64'h0);

    // Backpressure
    drive(1, 32'hA1, 0, 0);
    cyc();
    drive(1, 32'hA2, 0, 0);
    cyc();
    drive(1, 32'h33, 0, 0);
    held = out_data;
    chk("bp pair", held, 64'h0000_00A2_0000_00A1);
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready low", {63'h0, in_ready}, 64'h0);
      cyc();
      chk("bp out_data stable", out_data, 64'h0000_00A2_0000_00A1);
      chk("bp out_valid held", {63'h0, out_valid}, 64'h1);
    end
    drive(1, 32'h33, 0, 1);
    chk("bp release in_ready", {63'h0, in_ready}, 64'h1);
    cyc();
    chk("bp new low half", {63'h0, out_valid}, 64'h0);
    drive(1, 32'h44, 0, 1);
    cyc();
    chk("bp next pair", out_data, 64'h0000_0044_0000_0033);
    drive(0, 32'h0, 0, 1);
    cyc();

    // Flush ignored in EMPTY
    drive(0, 32'h0, 1, 1);
    cyc();
    chk("flush empty ignored", {63'h0, out_valid}, 64'h0);

    // Flush partial
    drive(1, 32'hDEAD_BEEF, 0, 1);
    cyc();
    drive(0, 32'h0, 1, 1);
    cyc();
    chk("flush partial data", out_data, 64'h0000_0000_DEAD_BEEF);
    chk("flush partial flag", {63'h0, out_partial}, 64'h1);
    drive(0, 32'h0, 0, 1);
    cyc();
    drive(1, 32'hDEAD_BEEF, 0, 1);
    cyc();
    drive(1, 32'h5, 1, 1);
    cyc();
    chk("flush+in data", out_data, 64'h0000_0005_DEAD_BEEF);
    chk("flush+in flag", {63'h0, out_partial}, 64'h0);
    drive(0, 32'h0, 0, 1);
    cyc();

    // Zero-bubble stream
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 0, 1);
      chk("stream in_ready", {63'h0, in_ready}, 64'h1);
      cyc();
      if (i % 2 == 0) begin
        chk("stream out_data", out_data, {32'(i), 32'(i - 1)});
      end
    end
    drive(0, 32'h0, 0, 1);
    cyc();

    // Mid-operation reset in HALF
    drive(1, 32'hA, 0, 1);
    cyc();
    drive(0, 32'h0, 0, 1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rst half out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst half in_ready", {63'h0, in_ready}, 64'h1);
    drive(1, 32'hB, 0, 1);
    cyc();
    drive(1, 32'hC, 0, 1);
    cyc();
    chk("rst half next pair", out_data, 64'h0000_000C_0000_000B);
    drive(0, 32'h0, 0, 1);
    cyc();

    // Reset while FULL and stalled discards the word
    drive(1, 32'h7, 0, 0);
    cyc();
    drive(1, 32'h8, 0, 0);
    cyc();
    drive(0, 32'h0, 0, 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("rst full out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst full out_data", out_data, 64'h0);

`ifdef PAIR_PACKER_COUNT_EN
    // Counter wrap
    force dut.pair_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.pair_count_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 32'h1, 0, 1);
    cyc();
    drive(1, 32'h2, 0, 1);
    cyc();
    chk("wrap before", {32'h0, pair_count}, 64'hFFFF_FFFF);
    drive(0, 32'h0, 0, 1);
    cyc();
    chk("wrap after", {32'h0, pair_count}, 64'h0);
`endif

    cyc();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
